// File: rtl/div_pkg.sv
// Shared types and constants for the iterative shift-and-subtract divider.
// Optional signed support is selected with the DIV_SIGNED_EN macro.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Start/done request bundle between a requester and div_unit.
// The is_signed request bit exists only when DIV_SIGNED_EN is defined.
interface div_unit_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef DIV_SIGNED_EN
    modport master (
        output start, dividend, divisor, is_signed,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, is_signed,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif

endinterface

// File: rtl/cla_subtractor.sv
// N-bit subtractor a - b computed as a + ~b + 1 with 4-bit carry-lookahead groups.
// The operand is zero-padded to whole groups; padded bits only propagate the carry.
module cla_subtractor #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    localparam int unsigned NG = (N + 3) / 4;
    localparam int unsigned NP = NG * 4;

    logic [NP-1:0] a_x;
    logic [NP-1:0] b_x;
    logic [NP-1:0] g;
    logic [NP-1:0] p;
    logic [NP:0]   c;
    logic          unused_carry;

    assign a_x  = NP'(a_i);
    assign b_x  = NP'(b_i);
    assign g    = a_x & ~b_x;
    assign p    = a_x ^ ~b_x;
    assign c[0] = 1'b1;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int unsigned B = 4 * k;
        logic grp_g;
        logic grp_p;

        assign grp_g = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];

        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = grp_g | (grp_p & c[B]);
    end

    assign diff_o   = p[N-1:0] ^ c[N-1:0];
    assign borrow_o = ~c[N];

    // Carries above bit N only ripple through padding.
    assign unused_carry = ^c;

endmodule

// File: rtl/div_unit.sv
// Iterative unsigned divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN to add two's-complement operation selected by is_signed.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = WIDTH + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PW-1:0]    shifted;
    logic [PW-1:0]    diff;
    logic             borrow;
    logic             unused_diff_top;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fin_rem;
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // Partial remainder picks up the next dividend bit, then trial-subtracts.
    assign shifted = {part_q, work_q[WIDTH-1]};

    cla_subtractor #(.N(PW)) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    // A successful trial is always below the divisor, so its top bit is zero.
    assign unused_diff_top = diff[WIDTH];
    assign step_rem        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo        = {work_q[WIDTH-2:0], ~borrow};

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
    logic dvd_neg;
    logic dvs_neg;

    assign dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign dvs_mag = dvs_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
    assign fin_quo = neg_quot_q ? (~step_quo + WIDTH'(1)) : step_quo;
    assign fin_rem = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign fin_quo = step_quo;
    assign fin_rem = step_rem;
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        work_d  = dvd_mag;
                        part_d  = '0;
                        dvs_d   = dvs_mag;
`ifdef DIV_SIGNED_EN
                        neg_quot_d = dvd_neg ^ dvs_neg;
                        neg_rem_d  = dvd_neg;
`endif
                    end
                end
            end
            RUN: begin
                part_d = step_rem;
                work_d = step_quo;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    quot_d  = fin_quo;
                    rem_d   = fin_rem;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            part_q  <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: latency, handshake, reset abort and results.
// Signed scenarios are compiled in when DIV_SIGNED_EN is defined.
module tb_div_unit;
    import div_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t last;
    int   checks   = 0;
    int   errors   = 0;
    int   op_cyc   = 0;
    int   busy_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        op_cyc++;
        if (bus.busy) busy_cnt++;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t e;
        e.dbz = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = a;
                e.r = '0;
            end else begin
                e.q = W'($signed(a) / $signed(b));
                e.r = W'($signed(a) % $signed(b));
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIV_SIGNED_EN
        bus.is_signed = sgn;
`endif
        sb.push_back(model(a, b, sgn));
        op_cyc   = 0;
        busy_cnt = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat, input int exp_busy);
        exp_t e;
        while (!bus.done && op_cyc < 200) tick();
        checks++;
        if (op_cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, op_cyc, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
        end else begin
            e    = sb.pop_front();
            last = e;
            if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
                errors++;
                $display("FAIL %s result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=%b",
                         name, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b q=%h r=%h dbz=%b, expected all zero",
                     name, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic check_idle_hold(input string name);
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
            bus.quotient !== last.q || bus.remainder !== last.r) begin
            errors++;
            $display("FAIL %s: got done=%b busy=%b q=%h r=%h, expected done=0 busy=0 q=%h r=%h",
                     name, bus.done, bus.busy, bus.quotient, bus.remainder, last.q, last.r);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check_outputs_zero("reset_state");
    endtask

    task automatic test_basic();
        issue(32'd100, 32'd7, 1'b0);
        wait_result("div_100_7", W + 1, W);
        check_idle_hold("done_pulse_100_7");
    endtask

    task automatic test_div_zero();
        issue(32'd5, 32'd0, 1'b0);
        wait_result("div_5_0", 1, 0);
        check_idle_hold("done_pulse_5_0");
    endtask

    task automatic test_back_to_back();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_result("div_max_1", W + 1, W);
        issue(32'd6, 32'd3, 1'b0);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got done=%b busy=%b, expected done=0 busy=1", bus.done, bus.busy);
        end
        wait_result("div_6_3_b2b", W + 1, W);
    endtask

    task automatic test_ignore_busy();
        issue(32'd100, 32'd7, 1'b0);
        while (op_cyc < 10) tick();
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd4;
        tick();
        bus.start = 1'b0;
        wait_result("ignore_start_busy", W + 1, W);
    endtask

    task automatic test_reset_mid();
        bit saw_done = 1'b0;
        issue(32'd100, 32'd7, 1'b0);
        while (op_cyc < 15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check_outputs_zero("reset_mid_run");
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_done: got done pulse, expected none");
        end
        issue(32'd12, 32'd5, 1'b0);
        wait_result("div_12_5_after_reset", W + 1, W);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
            issue(a, b, 1'b0);
            wait_result("random_unsigned", W + 1, W);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_result("signed_m7_2", W + 1, W);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_result("signed_overflow", W + 1, W);
        issue(32'hFFFF_FFEC, 32'd0, 1'b1);
        wait_result("signed_div_zero", 1, 0);
        issue(32'd20, 32'hFFFF_FFFD, 1'b1);
        wait_result("signed_20_m3", W + 1, W);
        issue(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_result("unsigned_big_2", W + 1, W);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_random();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative unsigned integer divider built around a carry-lookahead subtractor. It is the inverse companion to the adder chain: it computes quotient and remainder by shift-and-subtract, one quotient bit per clock. It sits beside the adder in the arithmetic datapath and is driven by a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits (multiple of 4, ≥ 8)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; accepted only when busy=0
- dividend  input  WIDTH  numerator, sampled on the accepting edge
- divisor  input  WIDTH  denominator, sampled on the accepting edge
- is_signed  input  1  two's-complement operation (present only with DIV_SIGNED_EN)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  last operation had divisor=0, held with results

## Operation
- Reset: state IDLE; busy, done, quotient, remainder, div_by_zero all 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start: latch operands; if divisor=0, go to DONE; else go to RUN, step counter=0. The busy=0 check covers both IDLE and DONE, so back-to-back operations are legal.
- Divide-by-zero result: quotient all-ones, remainder=dividend, div_by_zero=1.
- RUN, each cycle:
  - shift partial remainder left, bringing in the dividend MSB;
  - trial = partial − divisor via the subtractor (a + ~b + 1);
  - if no borrow, keep the trial and shift 1 into the quotient; else restore and shift 0.
  - After step WIDTH−1, go to DONE and register the results.
- DONE: done=1 for exactly one cycle, then IDLE unless start is present.
- start while busy=1: ignored. Operand changes during RUN have no effect.
- Arithmetic: partial remainder is WIDTH+1 bits internally; the borrow is the subtractor carry-out inverted.

## Timing
- busy=1 exactly in RUN.
- Normal latency: start accepted at edge E0; done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after the start cycle (33 for WIDTH=32).
- Divide-by-zero latency: done high the cycle after E0.
- Throughput: a new start may be accepted in the DONE cycle.
- A start sampled in DONE starts the new operation, and done drops next cycle.
- Results change only on the edge that enters DONE; they are stable otherwise.

## Configuration
- DIV_SIGNED_EN defined:
  - is_signed port exists.
  - When is_signed=1, operands are converted to magnitudes at load. Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Overflow case (most-negative / −1): quotient=most-negative, remainder=0, normal latency.
  - Signed divide-by-zero: quotient all-ones, remainder=dividend.
  - Sign fix-up is combinational at DONE entry; latency is unchanged.
- Undefined: no is_signed port; unsigned only; no sign logic synthesized.

## Structure
- Package div_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH constant;
  - counter width constant clog2(WIDTH).
- Sub-module cla_subtractor:
  - WIDTH+1-bit subtract built from 4-bit lookahead groups (g=a&~b, p=a^~b, carry-in 1);
  - outputs difference and borrow.
- Top: FSM, step counter, quotient/remainder shift registers, optional sign logic.

## Test plan
- 100 / 7 unsigned → quotient=14, remainder=2, div_by_zero=0, done exactly 33 cycles after the start cycle, busy high 32 cycles.
- 5 / 0 → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done the cycle after start.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0; then start in the DONE cycle with 6/3 → quotient=2, remainder=0.
- start pulsed with 9/4 at cycle 10 of a 100/7 run → ignored; results 14/2.
- rst asserted at cycle 15 of a run → next cycle all outputs 0, no done; a fresh 12/5 afterwards → 2/2.
- DIV_SIGNED_EN, is_signed=1:
  - −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
